// File: rtl/f_pc_fd_reg.sv
// Fetch-stage PC with AdEL detection and the F/D pipeline register.
// Handles stall hold, exception-request redirect/flush and eret delay-slot squash.
module f_pc_fd_reg #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_flush,
  input  logic        D_is_jump,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD
);

  logic        f_adel;
  logic [31:0] f_instr;
  logic [4:0]  f_exc;

  always_comb begin
    f_adel  = (F_pc[1:0] != 2'b00) || (F_pc < IM_BASE) || (F_pc > IM_LIMIT);
    f_instr = f_adel ? '0 : i_inst_rdata;
    f_exc   = f_adel ? 5'd4 : 5'd0;
  end

  assign i_inst_addr = F_pc;

  always_ff @(posedge clk) begin
    if (!reset)
      F_pc <= PC_RESET;
    else if (req)
      F_pc <= EXC_ENTRY;
    else if (!stall)
      F_pc <= npc;
  end

  // Bubbles keep a valid D_pc so CP0 always sees a meaningful macroscopic PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      D_instr   <= '0;
      D_pc      <= PC_RESET;
      D_ExcCode <= '0;
      D_BD      <= 1'b0;
    end else if (req) begin
      D_instr   <= '0;
      D_pc      <= EXC_ENTRY;
      D_ExcCode <= '0;
      D_BD      <= 1'b0;
    end else if (stall) begin
      D_instr   <= D_instr;
      D_pc      <= D_pc;
      D_ExcCode <= D_ExcCode;
      D_BD      <= D_BD;
    end else if (eret_flush) begin
      D_instr   <= '0;
      D_pc      <= F_pc;
      D_ExcCode <= '0;
      D_BD      <= 1'b0;
    end else begin
      D_instr   <= f_instr;
      D_pc      <= F_pc;
      D_ExcCode <= f_exc;
      D_BD      <= D_is_jump;
    end
  end

endmodule

// File: tb/tb_f_pc_fd_reg.sv
// Directed scoreboard bench for f_pc_fd_reg: a behavioural model pushes
// expected post-edge state, which is popped and compared after each edge.
module tb_f_pc_fd_reg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_flush, D_is_jump;
  logic [31:0] npc, i_inst_rdata, i_inst_addr, F_pc, D_instr, D_pc;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] dinstr;
    logic [31:0] dpc;
    logic [4:0]  dexc;
    logic        dbd;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3C01_1234;
    return {~a[15:0], a[15:0]};
  endfunction

  assign i_inst_rdata = im(i_inst_addr);

  f_pc_fd_reg #(
    .PC_RESET (PC_RESET),
    .EXC_ENTRY(EXC_ENTRY),
    .IM_BASE  (IM_BASE),
    .IM_LIMIT (IM_LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .stall       (stall),
    .req         (req),
    .eret_flush  (eret_flush),
    .D_is_jump   (D_is_jump),
    .i_inst_rdata(i_inst_rdata),
    .i_inst_addr (i_inst_addr),
    .F_pc        (F_pc),
    .D_instr     (D_instr),
    .D_pc        (D_pc),
    .D_ExcCode   (D_ExcCode),
    .D_BD        (D_BD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare.
  task automatic step(input logic rst_n, input logic [31:0] n, input logic st,
                      input logic rq, input logic er, input logic jp);
    exp_t e;
    logic adel;
    exp_t got;
    reset = rst_n; npc = n; stall = st; req = rq; eret_flush = er; D_is_jump = jp;
    adel = (m.fpc[1:0] != 2'b00) || (m.fpc < IM_BASE) || (m.fpc > IM_LIMIT);
    e = m;
    if (!rst_n) begin
      e.fpc = PC_RESET; e.dinstr = '0; e.dpc = PC_RESET; e.dexc = '0; e.dbd = 1'b0;
    end else if (rq) begin
      e.fpc = EXC_ENTRY; e.dinstr = '0; e.dpc = EXC_ENTRY; e.dexc = '0; e.dbd = 1'b0;
    end else if (!st) begin
      e.fpc = n;
      if (er) begin
        e.dinstr = '0; e.dpc = m.fpc; e.dexc = '0; e.dbd = 1'b0;
      end else begin
        e.dinstr = adel ? 32'h0 : im(m.fpc);
        e.dpc    = m.fpc;
        e.dexc   = adel ? 5'd4 : 5'd0;
        e.dbd    = jp;
      end
    end
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("F_pc", F_pc, got.fpc);
    chk("i_inst_addr", i_inst_addr, got.fpc);
    chk("D_instr", D_instr, got.dinstr);
    chk("D_pc", D_pc, got.dpc);
    chk("D_ExcCode", {27'd0, D_ExcCode}, {27'd0, got.dexc});
    chk("D_BD", {31'd0, D_BD}, {31'd0, got.dbd});
  endtask

  task automatic seq_to(input logic [31:0] target);
    for (int unsigned i = 0; i < 64 && m.fpc != target; i++)
      step(1'b1, m.fpc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_to_reached", F_pc, target);
  endtask

  initial begin
    m = '{fpc: 32'hX, dinstr: 32'hX, dpc: 32'hX, dexc: 5'hX, dbd: 1'bX};
    reset = 1'b0; npc = '0; stall = 1'b0; req = 1'b0; eret_flush = 1'b0; D_is_jump = 1'b0;
    @(negedge clk);

    // Reset, including concurrent req/stall.
    step(1'b0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_F_pc", F_pc, 32'h0000_3000);
    chk("rst_D_pc", D_pc, 32'h0000_3000);

    // First fetch after release.
    step(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_F_pc", F_pc, 32'h0000_3004);
    chk("first_D_instr", D_instr, 32'h3C01_1234);
    chk("first_D_pc", D_pc, 32'h0000_3000);
    chk("first_D_exc", {27'd0, D_ExcCode}, 32'd0);

    // Stall hold for three cycles at 0x3010.
    seq_to(32'h0000_3010);
    for (int unsigned i = 0; i < 3; i++)
      step(1'b1, 32'h0000_5555, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stall_hold_F_pc", F_pc, 32'h0000_3010);
    step(1'b1, 32'h0000_3014, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("unstall_D_pc", D_pc, 32'h0000_3010);

    // Misaligned and out-of-range fetches.
    step(1'b1, 32'h0000_3002, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("adel_mis_exc", {27'd0, D_ExcCode}, 32'd4);
    chk("adel_mis_instr", D_instr, 32'h0);
    chk("adel_mis_pc", D_pc, 32'h0000_3002);
    step(1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("adel_hi_exc", {27'd0, D_ExcCode}, 32'd4);
    chk("adel_hi_pc", D_pc, 32'h0000_7000);
    step(1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("limit_ok_exc", {27'd0, D_ExcCode}, 32'd0);
    step(1'b1, 32'h0000_3020, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("below_base_exc", {27'd0, D_ExcCode}, 32'd4);

    // Branch-delay flag.
    step(1'b1, 32'h0000_3024, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bd_D_pc", D_pc, 32'h0000_3020);
    chk("bd_set", {31'd0, D_BD}, 32'd1);
    step(1'b1, 32'h0000_3028, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bd_clear", {31'd0, D_BD}, 32'd0);

    // req beats stall.
    seq_to(32'h0000_3040);
    step(1'b1, 32'h0000_3044, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("req_F_pc", F_pc, 32'h0000_4180);
    chk("req_D_pc", D_pc, 32'h0000_4180);
    chk("req_D_instr", D_instr, 32'h0);

    // eret squash, then eret vs stall and eret vs req.
    step(1'b1, 32'h0000_3050, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3104, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("eret_D_instr", D_instr, 32'h0);
    chk("eret_D_pc", D_pc, 32'h0000_3050);
    chk("eret_F_pc", F_pc, 32'h0000_3104);
    step(1'b1, 32'h0000_3108, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3300, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("eret_stall_D_pc", D_pc, 32'h0000_3104);
    step(1'b1, 32'h0000_3300, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("eret_req_D_pc", D_pc, 32'h0000_4180);

    // Reset asserted during a stall.
    step(1'b1, 32'h0000_3200, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3204, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0000_3204, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_stall_F_pc", F_pc, 32'h0000_3000);
    chk("rst_stall_D_instr", D_instr, 32'h0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
